lcd_timing_ctrl: RTL and testbench
==================================

# lcd_timing_ctrl

Parametrised LCD panel timing controller: the next generation of the team's fixed-timing LCD driver. It generates pixel-clock, HS/VS/DE and RGB for a parallel RGB panel from the single system clock, using a clock-enable instead of a derived clock. It adds a configurable data-request lead and built-in test-pattern modes. It sits between the frame source (pixel_data/data_req handshake) and the panel pins; any tri-state pin muxing stays in the top level.

## Interface
- H_SYNC, 41: HS pulse width, pixel ticks
- H_BACK, 2: horizontal back porch
- H_DISP, 480: active pixels per line
- H_FRONT, 2: horizontal front porch
- V_SYNC, 10 / V_BACK, 2 / V_DISP, 272 / V_FRONT, 2: vertical equivalents, lines
- PCLK_DIV, 4: clk cycles per pixel tick; even, ≥2
- REQ_LAT, 1: data_req lead over lcd_de in ticks, 1..4
- DATA_W, 16: pixel width; 16 = RGB565, 24 = RGB888
- clk  in  1  system clock
- rst_n  in  1  one clock; reset is asynchronous and active-low
- mode  in  2  00 external, 01 colour bars, 10 solid, 11 checkerboard
- solid_color  in  DATA_W  colour for mode 10
- bl_en  in  1  backlight request
- pixel_data  in  DATA_W  external pixel for the last request
- data_req  out  1  pixel request (mode 00 only)
- pixel_xpos, pixel_ypos  out  11 each  coordinates of the requested pixel, 0 when data_req=0
- frame_start  out  1  one-clk pulse at each frame's first tick
- lcd_clk, lcd_hs, lcd_vs, lcd_de  out  1 each  panel timing; syncs are active low
- lcd_rgb  out  DATA_W  panel data
- lcd_rst, lcd_blk  out  1 each  panel reset (active low) and backlight

## Operation
- Divider div_cnt counts 0..PCLK_DIV-1. pix_ce = (div_cnt == PCLK_DIV-1). All panel outputs update only on pix_ce edges.
- Position register (h,v) holds the next position to display. It is (0,0) at reset.
- On pix_ce, outputs load the decode of (h,v), then h increments. When h wraps at H_TOTAL-1, h returns to 0 and v increments, wrapping at V_TOTAL-1. H_TOTAL is the sum of the four H parameters; V_TOTAL likewise.
- lcd_hs = 0 iff h < H_SYNC. lcd_vs = 0 iff v < V_SYNC.
- Active region: h ∈ [HA, HA+H_DISP) with HA = H_SYNC+H_BACK, and v ∈ [VA, VA+V_DISP) with VA = V_SYNC+V_BACK.
- lcd_de = 1 iff (h,v) is in the active region. Pixel coordinate is x = h-HA, y = v-VA.
- lcd_rgb is 0 outside the active region. Inside it, lcd_rgb comes from mode_q:
  - 00: pixel_data sampled on that same edge.
  - 01: 8 bars, bar width W = H_DISP/8 (integer), bar = min(x/W, 7). Colours in order: white, yellow, cyan, green, magenta, red, blue, black, with each channel all-ones or zero.
  - 10: solid_color.
  - 11: all-ones when x[3]^y[3] = 0, otherwise 0.
- data_req (mode_q = 00 only) loads 1 on pix_ce iff v is active and h+REQ_LAT is in the horizontal active window. pixel_xpos = h+REQ_LAT-HA and pixel_ypos = v-VA load at the same time.
- mode_q is reset to 00. It loads from mode only on the pix_ce that displays (0,0), so a mid-frame mode change takes effect at the next frame.
- lcd_rst goes to 1 on the first pix_ce after reset and stays 1.
- lcd_blk = bl_en, registered on pix_ce. It is forced to 0 until the second frame_start after reset.

## Timing
- Reset values: lcd_clk 0, lcd_hs 1, lcd_vs 1, lcd_de 0, lcd_rgb 0, lcd_rst 0, lcd_blk 0, data_req 0, pixel_xpos/ypos 0, frame_start 0, div_cnt 0.
- Reset is asynchronous. Asserting it mid-frame clears everything immediately. After release, the first pix_ce is the PCLK_DIV-th clk edge, and it displays (0,0).
- lcd_clk is 0 for the first PCLK_DIV/2 clk cycles after each output update and 1 for the remainder. The panel samples on the rising edge, mid-tick.
- frame_start is high for exactly the one clk cycle following the pix_ce edge that loads (0,0).
- Handshake: upstream must drive pixel_data for the requested pixel by the pix_ce edge REQ_LAT ticks after the edge that raised data_req. There is no back-pressure, so a late source is simply displayed late.
- Latency from a position to the panel pins: 1 clk after the pix_ce edge.

## Test plan
Benches use H = 2/2/8/2 (total 14), V = 1/1/4/1 (total 7), PCLK_DIV = 2, REQ_LAT = 1, DATA_W = 16 unless stated otherwise.
- Release reset:
  - first update at edge 2, with hs = vs = 0 and a frame_start pulse;
  - hs low for 4 clk in every 28;
  - vs low for 28 clk in every 196;
  - lcd_rst rises at edge 2;
  - with bl_en = 1, lcd_blk rises at the second frame_start.
- Mode 00, pixel_data = {ypos, xpos} echoed:
  - data_req on h = 3..10, v = 2..5, xpos 0..7;
  - de on h = 4..11;
  - lcd_rgb equals the request from one tick earlier;
  - 32 pixels per frame.
- Mode 01, H_DISP = 16: rgb pairs 0xFFFF, 0xFFE0, 0x07FF, 0x07E0, 0xF81F, 0xF800, 0x001F, 0x0000; data_req stays 0.
- Switch mode 00→10 mid-frame with solid_color = 0x1234: the current frame stays external; every active pixel of the next frame is 0x1234.
- Assert rst_n mid-line while de = 1: all outputs go to reset values before the next clk edge; after release, timing restarts at (0,0).
- REQ_LAT = 3: data_req first asserts at h = 1, 3 ticks before de, and ends at h = 8.

Source files
------------

// File: rtl/lcd_timing_ctrl.sv
// Parallel-RGB LCD timing controller: divides the system clock into a pixel tick,
// scans (h,v) over the panel raster and drives HS/VS/DE/RGB plus a data-request port.
module lcd_timing_ctrl #(
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int H_DISP   = 480,
  parameter int H_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2,
  parameter int V_DISP   = 272,
  parameter int V_FRONT  = 2,
  parameter int PCLK_DIV = 4,
  parameter int REQ_LAT  = 1,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] solid_color,
  input  logic              bl_en,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              data_req,
  output logic [10:0]       pixel_xpos,
  output logic [10:0]       pixel_ypos,
  output logic              frame_start,
  output logic              lcd_clk,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_rgb,
  output logic              lcd_rst,
  output logic              lcd_blk
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT   = H_SYNC + H_BACK;
  localparam int V_ACT   = V_SYNC + V_BACK;
  localparam int BAR_W   = (H_DISP / 8 > 0) ? (H_DISP / 8) : 1;
  localparam int DIV_W   = (PCLK_DIV > 2) ? $clog2(PCLK_DIV) : 1;

  localparam int B_W = (DATA_W == 24) ? 8 : 5;
  localparam int G_W = (DATA_W == 24) ? 8 : 6;
  localparam int R_W = DATA_W - G_W - B_W;

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(PCLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(PCLK_DIV / 2);

  localparam logic [10:0] C_H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] C_V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] C_HS      = 11'(H_SYNC);
  localparam logic [10:0] C_VS      = 11'(V_SYNC);
  localparam logic [10:0] C_HA      = 11'(H_ACT);
  localparam logic [10:0] C_HE      = 11'(H_ACT + H_DISP);
  localparam logic [10:0] C_VA      = 11'(V_ACT);
  localparam logic [10:0] C_VE      = 11'(V_ACT + V_DISP);
  localparam logic [10:0] C_BAR_W   = 11'(BAR_W);
  localparam logic [10:0] C_REQ11   = 11'(REQ_LAT);
  localparam logic [11:0] C_HA12    = 12'(H_ACT);
  localparam logic [11:0] C_HE12    = 12'(H_ACT + H_DISP);
  localparam logic [11:0] C_REQ12   = 12'(REQ_LAT);

  typedef enum logic [1:0] {
    MODE_EXT   = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_SOLID = 2'b10,
    MODE_CHECK = 2'b11
  } mode_e;

  // Bar index bits map directly onto the white..black sequence of primaries.
  function automatic logic [DATA_W-1:0] bar_color(input logic [2:0] bar);
    bar_color = {{R_W{~bar[1]}}, {G_W{~bar[2]}}, {B_W{~bar[0]}}};
  endfunction

  logic [DIV_W-1:0]  r_div;
  logic              r_lcd_clk;
  logic              r_frame_start;
  logic [10:0]       r_h;
  logic [10:0]       r_v;
  mode_e             r_mode_q;
  logic              r_hs;
  logic              r_vs;
  logic              r_de;
  logic [DATA_W-1:0] r_rgb;
  logic              r_data_req;
  logic [10:0]       r_xpos;
  logic [10:0]       r_ypos;
  logic              r_lcd_rst;
  logic              r_blk;
  logic              r_seen_origin;
  logic              r_blk_ok;

  logic              w_pix_ce;
  logic [DIV_W-1:0]  w_div_nxt;
  logic              w_at_origin;
  mode_e             w_mode_eff;
  logic              w_h_act;
  logic              w_v_act;
  logic [10:0]       w_x;
  logic [10:0]       w_y;
  logic [11:0]       w_hreq;
  logic [10:0]       w_xreq;
  logic              w_req;
  logic [10:0]       w_bar_q;
  logic [2:0]        w_bar;
  logic [DATA_W-1:0] w_rgb_nxt;
  logic [10:0]       w_h_nxt;
  logic [10:0]       w_v_nxt;
  logic              w_blk_allow;

  // Decode of the position about to be displayed on the next pixel tick.
  always_comb begin
    w_pix_ce = (r_div == C_DIV_LAST);
    if (w_pix_ce) begin
      w_div_nxt = '0;
    end else begin
      w_div_nxt = r_div + DIV_W'(1);
    end

    w_at_origin = (r_h == 11'd0) && (r_v == 11'd0);
    if (w_at_origin) begin
      w_mode_eff = mode_e'(mode);
    end else begin
      w_mode_eff = r_mode_q;
    end

    w_h_act = (r_h >= C_HA) && (r_h < C_HE);
    w_v_act = (r_v >= C_VA) && (r_v < C_VE);
    w_x     = r_h - C_HA;
    w_y     = r_v - C_VA;

    w_hreq  = {1'b0, r_h} + C_REQ12;
    w_xreq  = r_h + C_REQ11 - C_HA;
    w_req   = (w_mode_eff == MODE_EXT) && w_v_act &&
              (w_hreq >= C_HA12) && (w_hreq < C_HE12);

    w_bar_q = w_x / C_BAR_W;
    if (w_bar_q > 11'd7) begin
      w_bar = 3'd7;
    end else begin
      w_bar = w_bar_q[2:0];
    end

    w_rgb_nxt = '0;
    if (w_h_act && w_v_act) begin
      case (w_mode_eff)
        MODE_EXT:   w_rgb_nxt = pixel_data;
        MODE_BARS:  w_rgb_nxt = bar_color(w_bar);
        MODE_SOLID: w_rgb_nxt = solid_color;
        MODE_CHECK: w_rgb_nxt = (w_x[3] ^ w_y[3]) ? '0 : {DATA_W{1'b1}};
        default:    w_rgb_nxt = '0;
      endcase
    end else begin
      w_rgb_nxt = '0;
    end

    if (r_h == C_H_LAST) begin
      w_h_nxt = 11'd0;
      if (r_v == C_V_LAST) begin
        w_v_nxt = 11'd0;
      end else begin
        w_v_nxt = r_v + 11'd1;
      end
    end else begin
      w_h_nxt = r_h + 11'd1;
      w_v_nxt = r_v;
    end

    // Backlight stays dark until the second frame has begun.
    w_blk_allow = r_blk_ok || (w_at_origin && r_seen_origin);
  end

  // Pixel-tick divider; lcd_clk is low for the first half of each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_lcd_clk     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_lcd_clk     <= (w_div_nxt >= C_DIV_HALF);
      r_frame_start <= w_pix_ce && w_at_origin;
    end
  end

  // Raster scan and all panel/request outputs, advanced once per pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h           <= 11'd0;
      r_v           <= 11'd0;
      r_mode_q      <= MODE_EXT;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_data_req    <= 1'b0;
      r_xpos        <= 11'd0;
      r_ypos        <= 11'd0;
      r_lcd_rst     <= 1'b0;
      r_blk         <= 1'b0;
      r_seen_origin <= 1'b0;
      r_blk_ok      <= 1'b0;
    end else if (w_pix_ce) begin
      r_h        <= w_h_nxt;
      r_v        <= w_v_nxt;
      r_mode_q   <= w_mode_eff;
      r_hs       <= !(r_h < C_HS);
      r_vs       <= !(r_v < C_VS);
      r_de       <= w_h_act && w_v_act;
      r_rgb      <= w_rgb_nxt;
      r_data_req <= w_req;
      r_xpos     <= w_req ? w_xreq : 11'd0;
      r_ypos     <= w_req ? w_y : 11'd0;
      r_lcd_rst  <= 1'b1;
      r_blk      <= bl_en && w_blk_allow;
      if (w_at_origin) begin
        r_seen_origin <= 1'b1;
        r_blk_ok      <= r_seen_origin;
      end
    end
  end

  assign lcd_clk     = r_lcd_clk;
  assign frame_start = r_frame_start;
  assign lcd_hs      = r_hs;
  assign lcd_vs      = r_vs;
  assign lcd_de      = r_de;
  assign lcd_rgb     = r_rgb;
  assign data_req    = r_data_req;
  assign pixel_xpos  = r_xpos;
  assign pixel_ypos  = r_ypos;
  assign lcd_rst     = r_lcd_rst;
  assign lcd_blk     = r_blk;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl: two configurations run in lock-step against a
// raster model computed from the tick count since reset release.
module tb_lcd_timing_ctrl;

  localparam int NDUT = 2;

  typedef struct {
    int hs, hb, hd, hf, vs, vb, vd, vf, dv, rl;
  } cfg_t;

  cfg_t cfg [NDUT];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        bl_en;

  logic        d0_req, d0_fs, d0_clk, d0_hs, d0_vs, d0_de, d0_rst, d0_blk;
  logic [10:0] d0_x, d0_y;
  logic [15:0] d0_rgb, d0_pix;
  logic        d1_req, d1_fs, d1_clk, d1_hs, d1_vs, d1_de, d1_rst, d1_blk;
  logic [10:0] d1_x, d1_y;
  logic [15:0] d1_rgb, d1_pix;

  // Upstream source echoes the requested coordinates back as the pixel value.
  assign d0_pix = {d0_y[7:0], d0_x[7:0]};
  assign d1_pix = {d1_y[7:0], d1_x[7:0]};

  int n_checks = 0;
  int n_errors = 0;

  int          n_q     [NDUT];
  int          fm_q    [NDUT];
  logic [15:0] prevw_q [NDUT];
  int          de_cnt  [NDUT];
  logic        e_hs [NDUT], e_vs [NDUT], e_de [NDUT], e_req [NDUT], e_rst [NDUT], e_blk [NDUT];
  logic [15:0] e_rgb [NDUT];
  logic [10:0] e_x [NDUT], e_y [NDUT];

  logic [15:0] bar_tab [8];

  always #5 clk = ~clk;

  lcd_timing_ctrl #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .PCLK_DIV(2), .REQ_LAT(1), .DATA_W(16)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_color(solid_color),
    .bl_en(bl_en), .pixel_data(d0_pix), .data_req(d0_req),
    .pixel_xpos(d0_x), .pixel_ypos(d0_y), .frame_start(d0_fs),
    .lcd_clk(d0_clk), .lcd_hs(d0_hs), .lcd_vs(d0_vs), .lcd_de(d0_de),
    .lcd_rgb(d0_rgb), .lcd_rst(d0_rst), .lcd_blk(d0_blk)
  );

  lcd_timing_ctrl #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .PCLK_DIV(4), .REQ_LAT(3), .DATA_W(16)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_color(solid_color),
    .bl_en(bl_en), .pixel_data(d1_pix), .data_req(d1_req),
    .pixel_xpos(d1_x), .pixel_ypos(d1_y), .frame_start(d1_fs),
    .lcd_clk(d1_clk), .lcd_hs(d1_hs), .lcd_vs(d1_vs), .lcd_de(d1_de),
    .lcd_rgb(d1_rgb), .lcd_rst(d1_rst), .lcd_blk(d1_blk)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      n_q[i] = 0; fm_q[i] = 0; prevw_q[i] = 16'h0000; de_cnt[i] = 0;
      e_hs[i] = 1'b1; e_vs[i] = 1'b1; e_de[i] = 1'b0; e_req[i] = 1'b0;
      e_rst[i] = 1'b0; e_blk[i] = 1'b0; e_rgb[i] = 16'h0000;
      e_x[i] = 11'd0; e_y[i] = 11'd0;
    end
  endtask

  // Expected panel state after the tick that displays raster index p.
  task automatic model_tick(input int id, input logic de_obs);
    cfg_t c;
    int ht, vt, ft, p, h, v, ha, va, x, y, hr, bar;
    bit hact, vact, req;
    c  = cfg[id];
    ht = c.hs + c.hb + c.hd + c.hf;
    vt = c.vs + c.vb + c.vd + c.vf;
    ft = ht * vt;
    p  = n_q[id] / c.dv - 1;
    h  = p % ht;
    v  = (p / ht) % vt;
    ha = c.hs + c.hb;
    va = c.vs + c.vb;
    if (p % ft == 0) begin
      if (p > 0) chk($sformatf("d%0d.de_per_frame", id), de_cnt[id], c.hd * c.vd);
      de_cnt[id] = 0;
      fm_q[id] = int'(mode);
    end
    de_cnt[id] += int'(de_obs);
    hact = (h >= ha) && (h < ha + c.hd);
    vact = (v >= va) && (v < va + c.vd);
    x = h - ha;
    y = v - va;
    e_hs[id]  = !(h < c.hs);
    e_vs[id]  = !(v < c.vs);
    e_de[id]  = hact && vact;
    e_rst[id] = 1'b1;
    e_blk[id] = bl_en && (p >= ft);
    if (!(hact && vact)) begin
      e_rgb[id] = 16'h0000;
    end else begin
      case (fm_q[id])
        0: e_rgb[id] = prevw_q[id];
        1: begin
          bar = x / (c.hd / 8);
          if (bar > 7) bar = 7;
          e_rgb[id] = bar_tab[bar];
        end
        2: e_rgb[id] = solid_color;
        default: e_rgb[id] = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 16'h0000 : 16'hFFFF;
      endcase
    end
    hr  = h + c.rl;
    req = (fm_q[id] == 0) && vact && (hr >= ha) && (hr < ha + c.hd);
    e_req[id] = req;
    e_x[id]   = req ? 11'(hr - ha) : 11'd0;
    e_y[id]   = req ? 11'(y) : 11'd0;
    prevw_q[id] = {e_y[id][7:0], e_x[id][7:0]};
  endtask

  task automatic check_dut(input int id, input logic req, input logic [10:0] x,
                           input logic [10:0] y, input logic fs, input logic lclk,
                           input logic hs, input logic vs, input logic de,
                           input logic [15:0] rgb, input logic lrst, input logic blk);
    cfg_t c;
    int ft, n;
    bit tick, fs_e, clk_e;
    c    = cfg[id];
    n    = n_q[id];
    ft   = (c.hs + c.hb + c.hd + c.hf) * (c.vs + c.vb + c.vd + c.vf);
    tick = (n > 0) && (n % c.dv == 0);
    if (tick) model_tick(id, de);
    fs_e  = tick && ((n / c.dv - 1) % ft == 0);
    clk_e = (n % c.dv) >= (c.dv / 2);
    chk($sformatf("d%0d.hs", id), hs, e_hs[id]);
    chk($sformatf("d%0d.vs", id), vs, e_vs[id]);
    chk($sformatf("d%0d.de", id), de, e_de[id]);
    chk($sformatf("d%0d.rgb", id), rgb, e_rgb[id]);
    chk($sformatf("d%0d.req", id), req, e_req[id]);
    chk($sformatf("d%0d.xpos", id), x, e_x[id]);
    chk($sformatf("d%0d.ypos", id), y, e_y[id]);
    chk($sformatf("d%0d.frame_start", id), fs, fs_e);
    chk($sformatf("d%0d.lcd_clk", id), lclk, clk_e);
    chk($sformatf("d%0d.lcd_rst", id), lrst, e_rst[id]);
    chk($sformatf("d%0d.lcd_blk", id), blk, e_blk[id]);
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) if (rst_n) n_q[i]++;
    check_dut(0, d0_req, d0_x, d0_y, d0_fs, d0_clk, d0_hs, d0_vs, d0_de, d0_rgb, d0_rst, d0_blk);
    check_dut(1, d1_req, d1_x, d1_y, d1_fs, d1_clk, d1_hs, d1_vs, d1_de, d1_rgb, d1_rst, d1_blk);
  endtask

  task automatic reset_check();
    chk("rst.d0.hs", d0_hs, 1'b1);   chk("rst.d1.hs", d1_hs, 1'b1);
    chk("rst.d0.vs", d0_vs, 1'b1);   chk("rst.d1.vs", d1_vs, 1'b1);
    chk("rst.d0.de", d0_de, 1'b0);   chk("rst.d1.de", d1_de, 1'b0);
    chk("rst.d0.rgb", d0_rgb, 16'h0000); chk("rst.d1.rgb", d1_rgb, 16'h0000);
    chk("rst.d0.req", d0_req, 1'b0); chk("rst.d1.req", d1_req, 1'b0);
    chk("rst.d0.xpos", d0_x, 11'd0); chk("rst.d0.ypos", d0_y, 11'd0);
    chk("rst.d0.clk", d0_clk, 1'b0); chk("rst.d0.lcd_rst", d0_rst, 1'b0);
    chk("rst.d0.blk", d0_blk, 1'b0); chk("rst.d0.fs", d0_fs, 1'b0);
  endtask

  initial begin
    bit found;
    bar_tab[0] = 16'hFFFF; bar_tab[1] = 16'hFFE0; bar_tab[2] = 16'h07FF; bar_tab[3] = 16'h07E0;
    bar_tab[4] = 16'hF81F; bar_tab[5] = 16'hF800; bar_tab[6] = 16'h001F; bar_tab[7] = 16'h0000;
    cfg[0] = '{2, 2, 8, 2, 1, 1, 4, 1, 2, 1};
    cfg[1] = '{2, 2, 16, 2, 1, 1, 4, 1, 4, 3};
    rst_n = 1'b0; mode = 2'b00; solid_color = 16'h1234; bl_en = 1'b1;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    repeat (500) step();
    mode = 2'b10;
    repeat (700) step();
    mode = 2'b01;
    repeat (700) step();
    mode = 2'b11;
    repeat (700) step();

    for (int i = 0; i < 2000; i++) begin
      step();
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      solid_color = 16'($urandom);
      if ($urandom_range(0, 99) == 0) bl_en = ~bl_en;
    end
    mode = 2'b00; bl_en = 1'b1; solid_color = 16'h1234;

    // Drop reset in the middle of an active line.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (d0_de) found = 1'b1;
    end
    chk("d0.de_seen_before_reset", found, 1'b1);
    #1 rst_n = 1'b0;
    #1 reset_check();
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (800) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
